// File: rtl/ex_stage.sv
// ex_stage: execute stage with EX/MEM register and a 32-cycle iterative multiply/divide unit
// Ports:
//   Clk, Rst_n       rising-edge clock, asynchronous active-low reset
//   In_Valid         instruction present this cycle
//   In_ALUOp         operation select
//   In_A, In_B       operands (shift amount is In_A[4:0])
//   In_StoreData     rt value carried to MEM for stores
//   In_MEMControl    {MemWrite, MemRead}
//   In_WBControl     {RegWrite, MemtoReg}
//   In_WriteReg      destination register
//   In_Flush         synchronous squash, overrides everything
//   Out_*            EX/MEM register contents feeding the MEM stage
//   Stall            combinational; upstream holds In_* while high
module ex_stage #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    input  logic [3:0]       In_ALUOp,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic [WIDTH-1:0] In_StoreData,
    input  logic [1:0]       In_MEMControl,
    input  logic [1:0]       In_WBControl,
    input  logic [4:0]       In_WriteReg,
    input  logic             In_Flush,
    output logic [WIDTH-1:0] Out_Address,
    output logic [WIDTH-1:0] Out_Data,
    output logic [1:0]       Out_MEMControl,
    output logic [1:0]       Out_WBControl,
    output logic [4:0]       Out_WriteReg,
    output logic             Out_Valid,
    output logic             Stall
);
    localparam int CW = $clog2(MD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] md_hi, md_lo, md_b;
    logic [WIDTH-1:0] hi_nxt, lo_nxt, b_nxt;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] alu_res, md_res, res;
    logic [4:0]       shamt;
    logic             is_md, load_en;

    assign is_md  = In_ALUOp >= 4'd11 && In_ALUOp <= 4'd13;
    assign shamt  = In_A[4:0];

    always_comb begin
        alu_res = '0;
        case (In_ALUOp)
            4'd0:    alu_res = In_A + In_B;
            4'd1:    alu_res = In_A - In_B;
            4'd2:    alu_res = In_A & In_B;
            4'd3:    alu_res = In_A | In_B;
            4'd4:    alu_res = In_A ^ In_B;
            4'd5:    alu_res = ~(In_A | In_B);
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, $signed(In_A) < $signed(In_B)};
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, In_A < In_B};
            4'd8:    alu_res = In_B << shamt;
            4'd9:    alu_res = In_B >> shamt;
            4'd10:   alu_res = $signed(In_B) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // MUL: md_hi accumulates, md_lo is the multiplier consumed LSB first, md_b the shifting multiplicand.
    // DIVU/REMU: md_hi is the partial remainder, md_lo the dividend shifting out / quotient shifting in.
    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    assign rem_sh = {md_hi, md_lo[WIDTH-1]};
    assign rem_ge = rem_sh >= {1'b0, md_b};

    always_comb begin
        hi_nxt = rem_ge ? rem_sh[WIDTH-1:0] - md_b : rem_sh[WIDTH-1:0];
        lo_nxt = {md_lo[WIDTH-2:0], rem_ge};
        b_nxt  = md_b;
        if (md_op == 4'd11) begin
            hi_nxt = md_lo[0] ? md_hi + md_b : md_hi;
            lo_nxt = md_lo >> 1;
            b_nxt  = md_b << 1;
        end
    end

    assign md_res  = md_op == 4'd12 ? md_lo : md_hi;
    assign res     = state == DONE ? md_res : alu_res;
    assign load_en = state == DONE || (state == IDLE && In_Valid && !is_md);

    // Stall is forced low during reset so the held instruction cannot stall a reset pipeline.
    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                if (In_Valid && is_md) begin
                    state_nxt = BUSY;
                    Stall     = Rst_n;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (count == LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (In_Flush) state_nxt = IDLE;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
            md_op <= '0;
            md_hi <= '0;
            md_lo <= '0;
            md_b  <= '0;
        end else if (In_Flush) begin
            count <= '0;
        end else if (state == IDLE && In_Valid && is_md) begin
            count <= '0;
            md_op <= In_ALUOp;
            md_hi <= '0;
            md_lo <= In_A;
            md_b  <= In_B;
        end else if (state == BUSY) begin
            count <= count + CW'(1);
            md_hi <= hi_nxt;
            md_lo <= lo_nxt;
            md_b  <= b_nxt;
        end
    end

    // Bubbles clear only valid and control; address/data/dest hold their last values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out_Address    <= '0;
            Out_Data       <= '0;
            Out_MEMControl <= '0;
            Out_WBControl  <= '0;
            Out_WriteReg   <= '0;
            Out_Valid      <= 1'b0;
        end else if (!In_Flush && load_en) begin
            Out_Address    <= res;
            Out_Data       <= In_StoreData;
            Out_MEMControl <= In_MEMControl;
            Out_WBControl  <= In_WBControl;
            Out_WriteReg   <= In_WriteReg;
            Out_Valid      <= 1'b1;
        end else begin
            Out_MEMControl <= '0;
            Out_WBControl  <= '0;
            Out_Valid      <= 1'b0;
        end
    end
endmodule
